// File: rtl/lenet_cls_pkg.sv
// Shared types and constants for the LeNet5 argmax classifier stage.
package lenet_cls_pkg;

    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned CLASS_ID_W  = 4;

    localparam int ARITH_FIXED = 1;
    localparam int ARITH_FLOAT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } cls_state_e;

endpackage

// File: rtl/lenet_score_cmp.sv
// Strict "greater than" ordering of two scores, either signed fixed-point
// or IEEE-754 single precision mapped onto an unsigned sort key.
module lenet_score_cmp #(
    parameter int          ARITH_TYPE = 1,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  a_gt_b
);

    localparam logic [DATA_WIDTH-1:0] SIGN_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    function automatic logic [DATA_WIDTH-1:0] float_key(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? ~x : (x ^ SIGN_MASK);
    endfunction

    generate
        if (ARITH_TYPE == 1) begin : g_fixed
            assign a_gt_b = $signed(a) > $signed(b);
        end else begin : g_float
            // Negative floats invert so larger magnitude sorts lower; +0.0 lands above -0.0.
            assign a_gt_b = float_key(a) > float_key(b);
        end
    endgenerate

endmodule

// File: rtl/lenet_argmax_classifier.sv
// Captures the ten FC2 scores on start and scans them one per cycle,
// publishing the index and value of the maximum with a done pulse.
module lenet_argmax_classifier #(
    parameter int          ARITH_TYPE  = lenet_cls_pkg::ARITH_FIXED,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_CLASSES = lenet_cls_pkg::NUM_CLASSES,
    parameter int unsigned CLASS_ID_W  = lenet_cls_pkg::CLASS_ID_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] scores_in,
    output logic                              busy,
    output logic                              done,
    output logic                              result_valid,
    output logic [CLASS_ID_W-1:0]             class_id,
    output logic [DATA_WIDTH-1:0]             max_score
);

    import lenet_cls_pkg::*;

    cls_state_e              state_q, state_d;
    logic [DATA_WIDTH-1:0]   score_buf_q [NUM_CLASSES];
    logic [DATA_WIDTH-1:0]   score_buf_d [NUM_CLASSES];
    logic [CLASS_ID_W-1:0]   scan_idx_q, scan_idx_d;
    logic [DATA_WIDTH-1:0]   best_val_q, best_val_d;
    logic [CLASS_ID_W-1:0]   best_idx_q, best_idx_d;
    logic [CLASS_ID_W-1:0]   class_id_q, class_id_d;
    logic [DATA_WIDTH-1:0]   max_score_q, max_score_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    valid_q, valid_d;

    logic [DATA_WIDTH-1:0]   cur_score_c;
    logic                    cur_gt_c;
    logic                    accept_c;

    assign cur_score_c = score_buf_q[scan_idx_q];

    lenet_score_cmp #(
        .ARITH_TYPE (ARITH_TYPE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .a      (cur_score_c),
        .b      (best_val_q),
        .a_gt_b (cur_gt_c)
    );

    // DONE is the earliest re-arm point, giving one classification per 10 cycles.
    assign accept_c = start && (state_q == ST_IDLE || state_q == ST_DONE);

    always_comb begin
        state_d     = state_q;
        score_buf_d = score_buf_q;
        scan_idx_d  = scan_idx_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        class_id_d  = class_id_q;
        max_score_d = max_score_q;
        valid_d     = valid_q;
        done_d      = 1'b0;

        case (state_q)
            ST_SCAN: begin
                if (cur_gt_c) begin
                    best_val_d = cur_score_c;
                    best_idx_d = scan_idx_q;
                end
                scan_idx_d = scan_idx_q + CLASS_ID_W'(1);
                if (scan_idx_q == CLASS_ID_W'(NUM_CLASSES - 1)) begin
                    class_id_d  = cur_gt_c ? scan_idx_q : best_idx_q;
                    max_score_d = cur_gt_c ? cur_score_c : best_val_q;
                    done_d      = 1'b1;
                    valid_d     = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept_c) begin
            for (int k = 0; k < int'(NUM_CLASSES); k++) begin
                score_buf_d[k] = scores_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
            best_val_d = scores_in[DATA_WIDTH-1:0];
            best_idx_d = '0;
            scan_idx_d = CLASS_ID_W'(1);
            state_d    = ST_SCAN;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            for (int k = 0; k < int'(NUM_CLASSES); k++) begin
                score_buf_q[k] <= '0;
            end
            scan_idx_q  <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            class_id_q  <= '0;
            max_score_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_buf_q <= score_buf_d;
            scan_idx_q  <= scan_idx_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            class_id_q  <= class_id_d;
            max_score_q <= max_score_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = valid_q;
    assign class_id     = class_id_q;
    assign max_score    = max_score_q;

endmodule

// File: tb/tb_lenet_argmax_classifier.sv
// Checks fixed-point and float classifier instances against a transaction-level argmax model.
module tb_lenet_argmax_classifier;

    localparam int DW = 32;
    localparam int NC = 10;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [NC*DW-1:0] sin_fx = '0;
    logic [NC*DW-1:0] sin_fp = '0;

    logic          busy_fx, done_fx, valid_fx;
    logic [CW-1:0] cls_fx;
    logic [DW-1:0] max_fx;
    logic          busy_fp, done_fp, valid_fp;
    logic [CW-1:0] cls_fp;
    logic [DW-1:0] max_fp;

    int checks = 0;
    int errors = 0;

    lenet_argmax_classifier #(.ARITH_TYPE(1), .DATA_WIDTH(DW), .NUM_CLASSES(NC), .CLASS_ID_W(CW)) u_fx (
        .clk(clk), .reset(reset), .start(start), .scores_in(sin_fx),
        .busy(busy_fx), .done(done_fx), .result_valid(valid_fx),
        .class_id(cls_fx), .max_score(max_fx)
    );

    lenet_argmax_classifier #(.ARITH_TYPE(0), .DATA_WIDTH(DW), .NUM_CLASSES(NC), .CLASS_ID_W(CW)) u_fp (
        .clk(clk), .reset(reset), .start(start), .scores_in(sin_fp),
        .busy(busy_fp), .done(done_fp), .result_valid(valid_fp),
        .class_id(cls_fp), .max_score(max_fp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit greater(input logic [31:0] a, input logic [31:0] b, input bit flt);
        logic [31:0] ka, kb;
        if (!flt) return $signed(a) > $signed(b);
        ka = a[31] ? ~a : (a ^ 32'h8000_0000);
        kb = b[31] ? ~b : (b ^ 32'h8000_0000);
        return ka > kb;
    endfunction

    function automatic int argmax(input logic [NC*DW-1:0] v, input bit flt);
        int best = 0;
        for (int k = 1; k < NC; k++)
            if (greater(v[k*DW +: DW], v[best*DW +: DW], flt)) best = k;
        return best;
    endfunction

    int          m_cnt = 0;
    bit          m_valid = 0;
    int          m_cls [2] = '{0, 0};
    logic [31:0] m_max [2] = '{32'h0, 32'h0};
    int          p_cls [2];
    logic [31:0] p_max [2];

    // Transaction view: a run lasts 10 cycles; the result appears 9 edges after acceptance.
    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_valid = 0;
            m_cls = '{0, 0}; m_max = '{32'h0, 32'h0};
        end else begin
            if (start && m_cnt <= 1) begin
                p_cls[0] = argmax(sin_fx, 1'b0);
                p_max[0] = sin_fx[p_cls[0]*DW +: DW];
                p_cls[1] = argmax(sin_fp, 1'b1);
                p_max[1] = sin_fp[p_cls[1]*DW +: DW];
                m_cnt = 10;
            end else if (m_cnt > 0) begin
                m_cnt--;
            end
            if (m_cnt == 1) begin
                m_cls = p_cls; m_max = p_max; m_valid = 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("busy_fx",  32'(busy_fx),  32'(m_cnt > 0));
        check("done_fx",  32'(done_fx),  32'(m_cnt == 1));
        check("valid_fx", 32'(valid_fx), 32'(m_valid));
        check("class_fx", 32'(cls_fx),   32'(m_cls[0]));
        check("max_fx",   max_fx,        m_max[0]);
        check("busy_fp",  32'(busy_fp),  32'(m_cnt > 0));
        check("done_fp",  32'(done_fp),  32'(m_cnt == 1));
        check("valid_fp", 32'(valid_fp), 32'(m_valid));
        check("class_fp", 32'(cls_fp),   32'(m_cls[1]));
        check("max_fp",   max_fp,        m_max[1]);
    end

    // ---------------- stimulus ----------------
    function automatic logic [NC*DW-1:0] pack(input logic [31:0] a [NC]);
        logic [NC*DW-1:0] v;
        for (int k = 0; k < NC; k++) v[k*DW +: DW] = a[k];
        return v;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h0000_0000;
            2: return 32'(int'($urandom_range(0, 6)) - 3);
            3: return 32'h7FFF_FFFF;
            4: return 32'h3F00_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [NC*DW-1:0] rnd_vec();
        logic [NC*DW-1:0] v;
        for (int k = 0; k < NC; k++) v[k*DW +: DW] = rnd_word();
        return v;
    endfunction

    task automatic run_one(input logic [NC*DW-1:0] vfx, input logic [NC*DW-1:0] vfp);
        sin_fx = vfx; sin_fp = vfp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
    endtask

    logic [31:0] fix1 [NC];
    logic [31:0] flt1 [NC];
    logic [31:0] tmp  [NC];
    int bc, dc;

    initial begin
        fix1 = '{32'd5, 32'hFFFF_FFFD, 32'd12, 32'd7, 32'd12, 32'd0, 32'hFFFF_FF9C, 32'd11, 32'd2, 32'd1};
        flt1 = '{32'hBF80_0000, 32'h8000_0000, 32'h0000_0000, 32'hC020_0000, 32'h3F00_0000,
                 32'h3E80_0000, 32'h8000_0000, 32'h3F00_0000, 32'h3A83_126F, 32'hCE6E_6B28};

        repeat (2) @(negedge clk);
        check("rst_busy",  32'(busy_fx),  32'd0);
        check("rst_valid", 32'(valid_fx), 32'd0);
        check("rst_class", 32'(cls_fp),   32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed: tie keeps lower index; random inputs after capture must not matter.
        sin_fx = pack(fix1); sin_fp = pack(flt1); start = 1'b1;
        @(negedge clk);
        start = 1'b0; bc = 0; dc = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy_fx) bc++;
            if (done_fx) dc++;
            if (i == 9) begin
                check("t1_done",    32'(done_fx), 32'd1);
                check("t1_cls_fx",  32'(cls_fx),  32'd2);
                check("t1_max_fx",  max_fx,       32'd12);
                check("t1_cls_fp",  32'(cls_fp),  32'd4);
                check("t1_max_fp",  max_fp,       32'h3F00_0000);
            end
            sin_fx = rnd_vec(); sin_fp = rnd_vec();
            @(negedge clk);
        end
        check("t1_busy_cycles", 32'(bc), 32'd10);
        check("t1_done_pulses", 32'(dc), 32'd1);

        // Most-negative fixed values; last one slightly bigger.
        for (int k = 0; k < NC; k++) tmp[k] = 32'h8000_0000;
        tmp[9] = 32'h8000_0001;
        run_one(pack(tmp), pack(tmp));
        check("t2_cls_fx", 32'(cls_fx), 32'd9);
        check("t2_cls_fp", 32'(cls_fp), 32'd0);
        tmp[9] = 32'h8000_0000;
        run_one(pack(tmp), pack(tmp));
        check("t2_eq_cls_fx", 32'(cls_fx), 32'd0);

        // Only signed zeros: +0.0 wins.
        tmp[3] = 32'h0000_0000;
        run_one(pack(tmp), pack(tmp));
        check("t3_cls_fp", 32'(cls_fp), 32'd3);
        check("t3_max_fp", max_fp, 32'h0);

        // Restarts at E3/E9 ignored, restart at E10 accepted.
        sin_fx = pack(fix1); sin_fp = pack(flt1); start = 1'b1;
        @(negedge clk);
        start = 1'b0; sin_fx = rnd_vec(); sin_fp = rnd_vec();
        repeat (2) @(negedge clk);
        start = 1'b1; sin_fx = rnd_vec();
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; sin_fx = rnd_vec();
        @(negedge clk);
        check("t4_done1",  32'(done_fx), 32'd1);
        check("t4_cls1",   32'(cls_fx),  32'd2);
        for (int k = 0; k < NC; k++) tmp[k] = 32'd1;
        tmp[7] = 32'd50;
        sin_fx = pack(tmp);
        @(negedge clk);
        start = 1'b0;
        check("t4_hold_cls", 32'(cls_fx), 32'd2);
        repeat (9) @(negedge clk);
        check("t4_done2", 32'(done_fx), 32'd1);
        check("t4_cls2",  32'(cls_fx),  32'd7);
        check("t4_max2",  max_fx,       32'd50);
        repeat (2) @(negedge clk);

        // Reset mid-scan: no done, everything cleared.
        sin_fx = pack(fix1); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_busy",  32'(busy_fx),  32'd0);
        check("t5_valid", 32'(valid_fx), 32'd0);
        check("t5_max",   max_fx,        32'd0);
        dc = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_fx) dc++;
            @(negedge clk);
        end
        check("t5_no_done", 32'(dc), 32'd0);

        // Reset and start together: reset wins.
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("t6_busy", 32'(busy_fx), 32'd0);
        @(negedge clk);
        check("t6_busy2", 32'(busy_fx), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            start  = ($urandom_range(0, 3) == 0);
            reset  = ($urandom_range(0, 120) == 0);
            sin_fx = rnd_vec();
            sin_fp = rnd_vec();
            @(negedge clk);
        end
        start = 1'b0; reset = 1'b0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
